uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler.sv | 124 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// UART transmit scheduler: round-robin arbitration of four byte requesters onto one
// UART transmitter. A grant latches the winner's byte, pulses ack, then pulses tx_start.
// The scheduler then follows the transmitter's busy flag and waits out the post-stop pause
// on the next baud tick.
// Optional feature: define UART_TX_SCHED_TIMEOUT_EN to bound the wait for tx_busy to rise.
// The bound is BUSY_TIMEOUT cycles; when it expires, timeout_err is set and stays set.
module uart_tx_scheduler #(
  parameter int unsigned BUSY_TIMEOUT = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  input  logic        tx_en,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic [1:0]  grant_id,
  output logic        active,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitBusy,
    StWaitDone,
    StGap
  } state_e;

  state_e     state_q;
  logic [1:0] winner;
  logic [1:0] cand;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BUSY_TIMEOUT - 1);

  logic [CntW-1:0] busy_cnt_q;
`else
  // Without the timeout the parameter has no effect.
  logic unused_busy_timeout;
  assign unused_busy_timeout = ^BUSY_TIMEOUT;
  assign timeout_err = 1'b0;
`endif

  // Round-robin pick: the first requester after the last owner; the last owner ranks lowest.
  always_comb begin
    winner = grant_id;
    cand   = '0;
    for (int i = 4; i >= 1; i--) begin
      cand = grant_id + 2'(i);
      if (req[cand]) winner = cand;
    end
  end

  // Scheduler FSM. All outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ack         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      grant_id    <= 2'd3;
      active      <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      timeout_err <= 1'b0;
      busy_cnt_q  <= '0;
`endif
    end else begin
      ack      <= '0;
      tx_start <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req != '0) begin
            tx_data  <= req_data[8*winner +: 8];
            grant_id <= winner;
            ack      <= 4'b0001 << winner;
            active   <= 1'b1;
            state_q  <= StLaunch;
          end
        end
        StLaunch: begin
          tx_start <= 1'b1;
          state_q  <= StWaitBusy;
`ifdef UART_TX_SCHED_TIMEOUT_EN
          busy_cnt_q <= '0;
`endif
        end
        StWaitBusy: begin
          if (tx_busy) begin
            state_q <= StWaitDone;
          end
`ifdef UART_TX_SCHED_TIMEOUT_EN
          else if (busy_cnt_q == CntLast) begin
            // Transmitter never took the byte: flag it and drop the byte, no re-send.
            timeout_err <= 1'b1;
            active      <= 1'b0;
            state_q     <= StIdle;
          end else begin
            busy_cnt_q <= busy_cnt_q + CntW'(1);
          end
`endif
        end
        StWaitDone: begin
          // A coincident tx_en is deliberately ignored; only a tick seen in StGap counts.
          if (!tx_busy) state_q <= StGap;
        end
        StGap: begin
          if (tx_en) begin
            active  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          active  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios, then a randomized run.
// The randomized run is checked against a round-robin, transmitter and requester model.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        tx_en;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .BUSY_TIMEOUT(8)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .tx_en      (tx_en),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .grant_id   (grant_id),
    .active     (active),
    .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model state for the randomized run
  logic [7:0] byte_r [4];
  logic [7:0] exp_byte;
  int         last, w, idx, frames, en_cnt, delay, ticks;
  bit         pending, tx_act, aligned, gap_ok, frame_done, drop_now, quiet, stop;

  initial begin
    rst = 1'b1; req = '0; req_data = '0; tx_en = 1'b0; tx_busy = 1'b0;
    step();
    check("rst_ack", 32'(ack), 0);
    check("rst_start", 32'(tx_start), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_grant", 32'(grant_id), 3);
    check("rst_active", 32'(active), 0);
    check("rst_terr", 32'(timeout_err), 0);

    // Single request from requester 0
    rst = 1'b0; req = 4'b0001; req_data = 32'h0000_00A5;
    step();
    check("a5_ack", 32'(ack), 32'h1);
    check("a5_grant", 32'(grant_id), 0);
    check("a5_data", 32'(tx_data), 32'hA5);
    check("a5_nostart", 32'(tx_start), 0);
    check("a5_active", 32'(active), 1);
    req = '0;
    step();
    check("a5_start", 32'(tx_start), 1);
    check("a5_ack_clr", 32'(ack), 0);
    step();
    check("a5_start_1cyc", 32'(tx_start), 0);
    tx_busy = 1'b1;
    step();
    // Busy falls and a new request shows up at once: must wait for a tick in the gap
    tx_busy = 1'b0; req = 4'b0010; req_data = 32'h0000_3C00;
    step();
    quiet = 1'b0;
    repeat (10) begin
      step();
      quiet |= (ack != '0) || tx_start;
    end
    check("gap_hold", 32'(quiet), 0);
    tx_en = 1'b1;
    step();
    tx_en = 1'b0;
    check("gap_exit_noack", 32'(ack), 0);
    step();
    check("r1_ack", 32'(ack), 32'h2);
    check("r1_grant", 32'(grant_id), 1);
    check("r1_data", 32'(tx_data), 32'h3C);
    req = '0;
    step();
    check("r1_start", 32'(tx_start), 1);
    tx_busy = 1'b1;
    step();
    // Busy falls on a tick edge: that tick must not end the gap
    tx_busy = 1'b0; tx_en = 1'b1;
    step();
    tx_en = 1'b0; req = 4'b0110; req_data = 32'h0077_6600;
    quiet = 1'b0;
    repeat (5) begin
      step();
      quiet |= (ack != '0);
    end
    check("coincident_tick", 32'(quiet), 0);
    tx_en = 1'b1;
    step();
    tx_en = 1'b0;
    step();
    check("rr_ack", 32'(ack), 32'h4);
    check("rr_grant", 32'(grant_id), 2);
    check("rr_data", 32'(tx_data), 32'h77);
    req = 4'b0010;
    step();
    check("rr_start", 32'(tx_start), 1);
    // Transmitter never goes busy
    repeat (7) step();
    check("tmo_active_early", 32'(active), 1);
    step();
`ifdef UART_TX_SCHED_TIMEOUT_EN
    check("tmo_active", 32'(active), 0);
    check("tmo_err", 32'(timeout_err), 1);
`else
    check("tmo_active", 32'(active), 1);
    check("tmo_err", 32'(timeout_err), 0);
`endif
    rst = 1'b1; req = '0;
    #1;
    check("rst_terr_clr", 32'(timeout_err), 0);
    check("rst_active_clr", 32'(active), 0);
    step();
    rst = 1'b0; req = 4'b0100; req_data = 32'h0055_0000;
    step();
    check("r2_ack", 32'(ack), 32'h4);
    check("r2_data", 32'(tx_data), 32'h55);
    req = '0;
    step();
    tx_busy = 1'b1;
    step();
    step();
    // Asynchronous reset mid-frame (in the wait for busy to fall)
    #2; rst = 1'b1;
    #1;
    check("mid_rst_grant", 32'(grant_id), 3);
    check("mid_rst_data", 32'(tx_data), 0);
    check("mid_rst_active", 32'(active), 0);
    check("mid_rst_start", 32'(tx_start), 0);
    check("mid_rst_ack", 32'(ack), 0);
    @(posedge clk);
    #1;
    rst = 1'b0; tx_busy = 1'b0; req = 4'b1111; req_data = 32'h1312_1110;
    step();
    check("post_rst_ack", 32'(ack), 32'h1);
    check("post_rst_data", 32'(tx_data), 32'h10);

    // Randomized run: begins with all four held on bytes 10..13, then random traffic
    rst = 1'b1; req = 4'hF; tx_en = 1'b0; tx_busy = 1'b0;
    for (int i = 0; i < 4; i++) byte_r[i] = 8'h10 + 8'(i);
    req_data = {byte_r[3], byte_r[2], byte_r[1], byte_r[0]};
    last = 3; frames = 0; en_cnt = 0; pending = 0; tx_act = 0;
    gap_ok = 1; frame_done = 0; exp_byte = '0; delay = 0; ticks = 0; aligned = 0;
    step();
    rst = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      step();
      if (pending) begin
        check("start_after_ack", 32'(tx_start), 1);
        check("start_data", 32'(tx_data), 32'(exp_byte));
        pending = 0; tx_act = 1; delay = $urandom_range(0, 3); ticks = 0;
        aligned = 1'($urandom_range(0, 1)); gap_ok = 0; frame_done = 0;
      end else if (tx_start) begin
        check("spurious_start", 32'(tx_start), 0);
      end
      if (ack != '0) begin
        w = -1;
        for (int i = 1; i <= 4; i++) begin
          idx = (last + i) % 4;
          if (w < 0 && req[idx]) w = idx;
        end
        if (w < 0) begin
          check("ack_no_req", 32'(ack), 0);
        end else begin
          check("ack_onehot", 32'(ack), 32'(1) << w);
          check("ack_grant", 32'(grant_id), 32'(w));
          check("ack_data", 32'(tx_data), 32'(byte_r[w]));
          check("ack_after_gap", 32'(gap_ok), 1);
          check("ack_active", 32'(active), 1);
          last = w; exp_byte = byte_r[w]; pending = 1; frames++;
          if (frames < 6) begin
            // keep requesting the same byte
          end else if ($urandom_range(0, 1) == 1) begin
            byte_r[w] = 8'($urandom);
          end else begin
            req[w] = 1'b0;
          end
        end
      end
      stop = (cyc >= 5000);
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && !stop && $urandom_range(0, 7) == 0) begin
          req[i] = 1'b1;
          byte_r[i] = 8'($urandom);
        end
      end
      // Transmitter: tick every 16 cycles, busy for two ticks once it takes a byte
      drop_now = 0;
      tx_en = (en_cnt == 15);
      en_cnt = (en_cnt + 1) % 16;
      if (tx_act) begin
        if (!tx_busy) begin
          if (delay == 0) tx_busy = 1'b1;
          else delay--;
        end else begin
          if (tx_en) ticks++;
          if (ticks >= 2 && (aligned ? tx_en : ($urandom_range(0, 3) == 0))) begin
            check("hold_data", 32'(tx_data), 32'(exp_byte));
            tx_busy = 1'b0; tx_act = 0; frame_done = 1; drop_now = 1;
          end
        end
      end
      if (tx_en && frame_done && !drop_now) gap_ok = 1;
      req_data = {byte_r[3], byte_r[2], byte_r[1], byte_r[0]};
    end
    check("frames_done", 32'(frames >= 20), 1);
    check("idle_end", 32'(active), 0);
    check("req_drained", 32'(req), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
